// File: rtl/exit_park.sv
// exit_park: exit-side slot occupancy, per-slot parking timers and exit FSM.
// Ports: clk, rst_n; entry_valid/entry_slot in; exit_req/exit_slot in;
// parking_capacity (1 = free), busy, exit_done, exit_error, entry_error,
// fee, free_count out.
module exit_park #(
  parameter int TICK_DIV     = 4,
  parameter int FEE_PER_UNIT = 2,
  parameter int TIME_W       = 12,
  parameter int FEE_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_valid,
  input  logic [2:0]       entry_slot,
  input  logic             exit_req,
  input  logic [2:0]       exit_slot,
  output logic [7:0]       parking_capacity,
  output logic             busy,
  output logic             exit_done,
  output logic             exit_error,
  output logic             entry_error,
  output logic [FEE_W-1:0] fee,
  output logic [3:0]       free_count
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int MW = TIME_W + FEE_W;
  localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] FPU = MW'(FEE_PER_UNIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]     presc_q, presc_d;
  logic [TIME_W-1:0] cnt_q [8];
  logic [TIME_W-1:0] cnt_d [8];
  logic [7:0]        cap_q, cap_d;
  logic [3:0]        free_q, free_d;
  logic [FEE_W-1:0]  fee_q, fee_d;
  logic [2:0]        slot_q, slot_d;
  logic [TIME_W-1:0] units_q, units_d;
  logic              done_q, done_d;
  logic              xerr_q, xerr_d;
  logic              eerr_q, eerr_d;

  logic              tick;
  logic              rel;
  logic              entry_ok;
  logic [TIME_W-1:0] units_eff;
  logic [MW-1:0]     prod;
  logic [FEE_W-1:0]  fee_sat;

  assign tick = (presc_q == PLAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // A parked car is always billed at least one unit.
  assign units_eff = (units_q == '0) ? TIME_W'(1) : units_q;
  assign prod      = MW'(units_eff) * FPU;
  assign fee_sat   = (|prod[MW-1:FEE_W]) ? '1 : prod[FEE_W-1:0];

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    units_d = units_q;
    fee_d   = fee_q;
    done_d  = 1'b0;
    xerr_d  = 1'b0;
    rel     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (exit_req) begin
          slot_d  = exit_slot;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cap_q[slot_q]) begin
          xerr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          units_d = cnt_q[slot_q];
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        fee_d   = fee_sat;
        rel     = 1'b1;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Entry is judged against the current vector, so an entry landing on
  // the slot being released in the same cycle is reported as an error.
  always_comb begin
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    free_d   = '0;
    entry_ok = entry_valid && cap_q[entry_slot];
    eerr_d   = entry_valid && !cap_q[entry_slot];
    for (int i = 0; i < 8; i++) begin
      if (tick && !cap_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + TIME_W'(1);
      end
    end
    if (rel) begin
      cap_d[slot_q] = 1'b1;
    end
    if (entry_ok) begin
      cap_d[entry_slot] = 1'b0;
      cnt_d[entry_slot] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      free_d = free_d + 4'(cap_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      cap_q   <= 8'hFF;
      free_q  <= 4'd8;
      fee_q   <= '0;
      slot_q  <= '0;
      units_q <= '0;
      done_q  <= 1'b0;
      xerr_q  <= 1'b0;
      eerr_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cap_q   <= cap_d;
      free_q  <= free_d;
      fee_q   <= fee_d;
      slot_q  <= slot_d;
      units_q <= units_d;
      done_q  <= done_d;
      xerr_q  <= xerr_d;
      eerr_q  <= eerr_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign parking_capacity = cap_q;
  assign busy             = (state_q != S_IDLE);
  assign exit_done        = done_q;
  assign exit_error       = xerr_q;
  assign entry_error      = eerr_q;
  assign fee              = fee_q;
  assign free_count       = free_q;

endmodule

// File: tb/tb_exit_park.sv
// tb_exit_park: scoreboard bench for exit_park, default instance plus a
// narrow TIME_W=4/FEE_W=4 instance for saturation, sharing stimulus.
`timescale 1ns/1ps
module tb_exit_park;

  localparam int TD  = 4;
  localparam int FPU = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        entry_valid = 1'b0;
  logic [2:0]  entry_slot = '0;
  logic        exit_req = 1'b0;
  logic [2:0]  exit_slot = '0;

  logic [7:0]  cap, cap_s;
  logic        busy, busy_s;
  logic        done, done_s;
  logic        xerr, xerr_s;
  logic        eerr, eerr_s;
  logic [15:0] fee;
  logic [3:0]  fee_s;
  logic [3:0]  free, free_s;

  int total = 0;
  int bad = 0;
  int ecnt;
  int ent_edge [8];
  int q_main [$];
  int q_sat [$];

  exit_park dut (
    .clk(clk), .rst_n(rst_n),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_req(exit_req), .exit_slot(exit_slot),
    .parking_capacity(cap), .busy(busy),
    .exit_done(done), .exit_error(xerr), .entry_error(eerr),
    .fee(fee), .free_count(free)
  );

  exit_park #(.TIME_W(4), .FEE_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .entry_valid(entry_valid), .entry_slot(entry_slot),
    .exit_req(exit_req), .exit_slot(exit_slot),
    .parking_capacity(cap_s), .busy(busy_s),
    .exit_done(done_s), .exit_error(xerr_s), .entry_error(eerr_s),
    .fee(fee_s), .free_count(free_s)
  );

  always #5 clk = ~clk;

  // Edge number since reset release: after edge e this reads e.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else ecnt <= ecnt + 1;
  end

  function automatic int fee_of(int u, int tw, int fw);
    int c;
    int f;
    c = (u > (1 << tw) - 1) ? (1 << tw) - 1 : u;
    if (c < 1) c = 1;
    f = c * FPU;
    if (f > (1 << fw) - 1) f = (1 << fw) - 1;
    return f;
  endfunction

  function automatic int pop_main();
    if (q_main.size() == 0) return -1;
    return q_main.pop_front();
  endfunction

  function automatic int pop_sat();
    if (q_sat.size() == 0) return -1;
    return q_sat.pop_front();
  endfunction

  task automatic drive_entry(input int s, input bit rec);
    entry_valid = 1'b1;
    entry_slot  = 3'(s);
    if (rec) ent_edge[s] = ecnt + 1;
    @(negedge clk);
    entry_valid = 1'b0;
  endtask

  // Ticks land on edges that are multiples of TD; the slot is snapshotted
  // from the counter value left by edge k.
  task automatic drive_exit(input int s, input bit push);
    int k;
    int u;
    k = ecnt + 1;
    u = k / TD - ent_edge[s] / TD;
    if (push) begin
      q_main.push_back(fee_of(u, 12, 16));
      q_sat.push_back(fee_of(u, 4, 4));
    end
    exit_req  = 1'b1;
    exit_slot = 3'(s);
    @(negedge clk);
    exit_req = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (cap !== 8'hFF) begin bad++; $display("FAIL rst_cap got=%h exp=ff", cap); end
    total++; if (free !== 4'd8) begin bad++; $display("FAIL rst_free got=%0d exp=8", free); end
    total++; if (fee !== 16'd0) begin bad++; $display("FAIL rst_fee got=%0d exp=0", fee); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if ({done, xerr, eerr} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {done, xerr, eerr}); end
  endtask

  task automatic test_basic_exit();
    int lat;
    int em;
    int es;
    rst_n = 1'b1;
    drive_entry(7, 1'b1);
    total++; if (cap !== 8'h7F) begin bad++; $display("FAIL basic_cap_entry got=%h exp=7f", cap); end
    total++; if (free !== 4'd7) begin bad++; $display("FAIL basic_free_entry got=%0d exp=7", free); end
    repeat (38) @(negedge clk);
    q_main.push_back(20);
    q_sat.push_back(15);
    drive_exit(7, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    wait_done(lat);
    em = pop_main();
    es = pop_sat();
    total++; if (lat !== 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    total++; if (fee !== 16'(em)) begin bad++; $display("FAIL basic_fee got=%0d exp=%0d", fee, em); end
    total++; if (fee_s !== 4'(es)) begin bad++; $display("FAIL basic_fee_sat got=%0d exp=%0d", fee_s, es); end
    total++; if (cap !== 8'hFF) begin bad++; $display("FAIL basic_cap_rel got=%h exp=ff", cap); end
    total++; if (free !== 4'd8) begin bad++; $display("FAIL basic_free_rel got=%0d exp=8", free); end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL basic_idle got=%b exp=00", {done, busy}); end
  endtask

  task automatic test_min_fee();
    int lat;
    int em;
    int es;
    drive_entry(3, 1'b1);
    drive_exit(3, 1'b1);
    wait_done(lat);
    em = pop_main();
    es = pop_sat();
    total++; if (lat !== 2) begin bad++; $display("FAIL min_latency got=%0d exp=2", lat); end
    total++; if (fee !== 16'(em)) begin bad++; $display("FAIL min_fee got=%0d exp=%0d", fee, em); end
    total++; if (fee !== 16'd2) begin bad++; $display("FAIL min_fee_const got=%0d exp=2", fee); end
    total++; if (fee_s !== 4'(es)) begin bad++; $display("FAIL min_fee_sat got=%0d exp=%0d", fee_s, es); end
    @(negedge clk);
  endtask

  task automatic test_invalid_exit();
    int nd;
    drive_entry(0, 1'b1);
    total++; if (cap !== 8'hFE) begin bad++; $display("FAIL inv_cap_pre got=%h exp=fe", cap); end
    drive_exit(4, 1'b0);
    @(negedge clk);
    total++; if (xerr !== 1'b1) begin bad++; $display("FAIL inv_xerr got=%b exp=1", xerr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL inv_busy got=%b exp=0", busy); end
    nd = (done === 1'b1) ? 1 : 0;
    @(negedge clk);
    total++; if (xerr !== 1'b0) begin bad++; $display("FAIL inv_xerr_pulse got=%b exp=0", xerr); end
    repeat (3) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL inv_no_done got=%0d exp=0", nd); end
    total++; if (fee !== 16'd2) begin bad++; $display("FAIL inv_fee got=%0d exp=2", fee); end
    total++; if (cap !== 8'hFE) begin bad++; $display("FAIL inv_cap got=%h exp=fe", cap); end
  endtask

  task automatic test_collisions();
    int nd;
    int em;
    int es;
    repeat (9) @(negedge clk);
    drive_entry(0, 1'b0);
    total++; if (eerr !== 1'b1) begin bad++; $display("FAIL col_eerr got=%b exp=1", eerr); end
    total++; if (cap !== 8'hFE) begin bad++; $display("FAIL col_cap got=%h exp=fe", cap); end
    @(negedge clk);
    total++; if (eerr !== 1'b0) begin bad++; $display("FAIL col_eerr_pulse got=%b exp=0", eerr); end
    drive_entry(6, 1'b1);
    drive_exit(0, 1'b1);
    nd = 0;
    exit_req  = 1'b1;
    exit_slot = 3'd6;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        em = pop_main();
        es = pop_sat();
        total++; if (fee !== 16'(em)) begin bad++; $display("FAIL col_busy_fee got=%0d exp=%0d", fee, em); end
        total++; if (fee_s !== 4'(es)) begin bad++; $display("FAIL col_busy_fee_sat got=%0d exp=%0d", fee_s, es); end
      end
    end
    exit_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    total++; if (nd !== 1) begin bad++; $display("FAIL col_ignored got=%0d exp=1", nd); end
    total++; if (cap !== 8'hBF) begin bad++; $display("FAIL col_cap_busy got=%h exp=bf", cap); end
    total++; if (free !== 4'd7) begin bad++; $display("FAIL col_free_busy got=%0d exp=7", free); end
    drive_exit(6, 1'b1);
    @(negedge clk);
    entry_valid = 1'b1;
    entry_slot  = 3'd6;
    @(negedge clk);
    entry_valid = 1'b0;
    em = pop_main();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL col_rel_done got=%b exp=1", done); end
    total++; if (eerr !== 1'b1) begin bad++; $display("FAIL col_rel_eerr got=%b exp=1", eerr); end
    total++; if (fee !== 16'(em)) begin bad++; $display("FAIL col_rel_fee got=%0d exp=%0d", fee, em); end
    es = pop_sat();
    total++; if (fee_s !== 4'(es)) begin bad++; $display("FAIL col_rel_fee_sat got=%0d exp=%0d", fee_s, es); end
    @(negedge clk);
    total++; if (cap !== 8'hFF) begin bad++; $display("FAIL col_rel_cap got=%h exp=ff", cap); end
    total++; if (eerr !== 1'b0) begin bad++; $display("FAIL col_rel_eerr_pulse got=%b exp=0", eerr); end
  endtask

  task automatic test_full();
    for (int s = 0; s < 8; s++) begin
      drive_entry(s, 1'b1);
      total++; if (free !== 4'(7 - s)) begin bad++; $display("FAIL full_free%0d got=%0d exp=%0d", s, free, 7 - s); end
    end
    total++; if (cap !== 8'h00) begin bad++; $display("FAIL full_cap got=%h exp=00", cap); end
    total++; if (cap_s !== 8'h00) begin bad++; $display("FAIL full_cap_s got=%h exp=00", cap_s); end
  endtask

  task automatic test_saturation();
    int k;
    int n;
    int lat;
    int em;
    int es;
    // Hold slot 1 for 66 units: a wrapping 4-bit counter would read 2.
    k = TD * (66 + ent_edge[1] / TD);
    n = k - ecnt - 1;
    repeat (n) @(negedge clk);
    drive_exit(1, 1'b1);
    wait_done(lat);
    em = pop_main();
    es = pop_sat();
    total++; if (lat !== 2) begin bad++; $display("FAIL sat_latency got=%0d exp=2", lat); end
    total++; if (fee !== 16'(em)) begin bad++; $display("FAIL sat_fee_main got=%0d exp=%0d", fee, em); end
    total++; if (fee_s !== 4'(es)) begin bad++; $display("FAIL sat_fee got=%0d exp=%0d", fee_s, es); end
    total++; if (fee_s !== 4'd15) begin bad++; $display("FAIL sat_fee_const got=%0d exp=15", fee_s); end
    @(negedge clk);
    total++; if (cap !== 8'h02) begin bad++; $display("FAIL sat_cap got=%h exp=02", cap); end
  endtask

  task automatic test_async_reset();
    int nd;
    drive_exit(5, 1'b1);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_busy_pre got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    #1;
    q_main.delete();
    q_sat.delete();
    total++; if (cap !== 8'hFF) begin bad++; $display("FAIL ar_cap got=%h exp=ff", cap); end
    total++; if (free !== 4'd8) begin bad++; $display("FAIL ar_free got=%0d exp=8", free); end
    total++; if (fee !== 16'd0) begin bad++; $display("FAIL ar_fee got=%0d exp=0", fee); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
    total++; if (fee_s !== 4'd0) begin bad++; $display("FAIL ar_fee_s got=%0d exp=0", fee_s); end
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL ar_lost got=%0d exp=0", nd); end
    total++; if (cap !== 8'hFF) begin bad++; $display("FAIL ar_cap_post got=%h exp=ff", cap); end
  endtask

  initial begin
    test_reset();
    test_basic_exit();
    test_min_fee();
    test_invalid_exit();
    test_collisions();
    test_full();
    test_saturation();
    test_async_reset();
    total++; if (q_main.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", q_main.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exit_park.md
# exit_park

Sequential exit-side counterpart of the parking entry allocator. It owns the slot occupancy vector (`parking_capacity`, bit set = slot free) that the entry allocator reads. It registers cars parked by the entry side and times each occupied slot with a prescaled per-slot counter. It services exit requests through a small FSM that validates the slot, computes the parking fee and releases the slot back to the free pool.

## Interface

Parameters:
- `TICK_DIV`, default 4: clock cycles per time unit; range ≥ 2.
- `FEE_PER_UNIT`, default 2: fee charged per elapsed time unit.
- `TIME_W`, default 12: width of each per-slot elapsed-unit counter.
- `FEE_W`, default 16: fee output width.

Ports (8 slots fixed; slot index 3 bits):
- `clk`  in  1  — system clock; all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `entry_valid`  in  1  — one-cycle pulse: a car has taken slot `entry_slot`.
- `entry_slot`  in  3  — slot index from the entry allocator's `park_number`.
- `exit_req`  in  1  — request to release slot `exit_slot`; sampled only in IDLE.
- `exit_slot`  in  3  — slot being vacated.
- `parking_capacity`  out  8  — occupancy vector; bit i = 1 means slot i is free.
- `busy`  out  1  — FSM not in IDLE.
- `exit_done`  out  1  — one-cycle pulse: fee valid, slot released.
- `exit_error`  out  1  — one-cycle pulse: exit requested on a free slot.
- `entry_error`  out  1  — one-cycle pulse: entry on an already-occupied slot.
- `fee`  out  `FEE_W`  — fee of the last successful exit; held until the next one.
- `free_count`  out  4  — number of set bits in `parking_capacity` (0..8), registered.

## Operation

- Reset: `parking_capacity` = 8'hFF, `free_count` = 8, `fee` = 0, all pulses 0, `busy` = 0, prescaler = 0, all slot counters = 0, FSM = IDLE.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 and wraps.
  - `tick` is asserted in the cycle the prescaler equals `TICK_DIV`-1.
  - Free-running from reset.
- Slot counters:
  - On `tick`, each occupied slot's counter increments, saturating at 2^`TIME_W`-1.
  - Counters of free slots hold.
- Entry:
  - `entry_valid` on a free slot clears its capacity bit and zeroes its counter. The zeroing overrides a same-cycle tick.
  - `entry_valid` on an occupied slot changes no state and pulses `entry_error`.
  - Entry is accepted in any FSM state.
- FSM states: IDLE, CHECK, CALC, DONE.
  - IDLE: on `exit_req`, latch `exit_slot` → CHECK.
  - CHECK:
    - If the latched slot is free: pulse `exit_error` → IDLE.
    - Otherwise: snapshot that slot's counter → CALC.
  - CALC:
    - `fee` = max(units, 1) × `FEE_PER_UNIT`, saturating at 2^`FEE_W`-1.
    - Set the slot's capacity bit and pulse `exit_done` (both take effect at the same edge) → DONE.
  - DONE: single cycle → IDLE.
- `exit_req` outside IDLE is ignored, not queued.
- Same-cycle entry and release on the same slot:
  - Release is evaluated first, so the entry sees the slot as occupied.
  - Result: `entry_error` pulses and the slot becomes free.
- `free_count` is recomputed every cycle from the next-state capacity vector, so it is coherent with `parking_capacity`.
- Arithmetic: fee product computed at `TIME_W`+`FEE_W` width, then saturated.

## Timing

- Exit request sampled at edge k (IDLE):
  - Edge k+1: CHECK evaluation. On a free slot, `exit_error` is high for the cycle after k+1 and the FSM is back in IDLE.
  - Edge k+2: `fee` updated, capacity bit set, `exit_done` high for one cycle, FSM in DONE.
  - Edge k+3: IDLE; next `exit_req` accepted.
  - Success latency: 2 cycles. Issue rate: one exit per 3 cycles.
- Entry: capacity bit clears and `free_count` updates at the sampling edge. Visible to the entry allocator the following cycle.
- `entry_error` / `exit_error` / `exit_done` are registered one-cycle pulses.
- `busy` is high from edge k+1 until the edge that returns the FSM to IDLE.
- Asynchronous reset mid-exit: FSM → IDLE immediately and every output takes its reset value. The in-flight exit is lost and the slot reads free (vector reset to 8'hFF).

## Test plan

- Reset: assert `rst_n`=0 mid-operation with slots 2 and 5 occupied → immediately `parking_capacity`=8'hFF, `free_count`=8, `fee`=0, `busy`=0.
- Basic timed exit (`TICK_DIV`=4, `FEE_PER_UNIT`=2):
  - `entry_valid`/`entry_slot`=7 at the first edge after reset release.
  - `exit_req`/`exit_slot`=7 at edge 40.
  - Expect `parking_capacity`=8'h7F after entry, `exit_done` after edge 42, `fee`=20, capacity back to 8'hFF.
- Minimum fee: entry slot 3, immediate exit on the next edge → `fee`=2 (one unit), `exit_done` pulses.
- Invalid exit: `exit_req` on free slot 4 → `exit_error` pulse after edge k+1, no `exit_done`, `fee` unchanged, capacity unchanged.
- Collisions:
  - Entry into occupied slot 0 → `entry_error` pulse, counter not cleared.
  - `exit_req` while `busy` → ignored.
  - Entry on the exiting slot at the release edge → `entry_error`, slot free.
- Full/saturation:
  - Fill all 8 slots → `parking_capacity`=8'h00, `free_count`=0.
  - With `TIME_W`=4 and `FEE_W`=4, hold a slot for more than 15 units → counter stays at 15 and `fee`=15 (saturated).
